// File: rtl/conv2_feed_ctrl.sv
// conv2 feed sequencer: streams channels from the pool1 RAM into the 5x5
// window buffer and strobes the partial-sum accumulator. Option: CONV2_FEED_STALL_EN.
module conv2_feed_ctrl #(
   parameter int WIDTH     = 12,
   parameter int HEIGHT    = 12,
   parameter int CHANNELS  = 3,
   parameter int DATA_BIT  = 12,
   parameter int ADDR_BIT  = 9,
   parameter int FLUSH_LEN = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
`ifdef CONV2_FEED_STALL_EN
   input  logic                stall,
`endif
   output logic                mem_rd,
   output logic [ADDR_BIT-1:0] mem_addr,
   input  logic [DATA_BIT-1:0] mem_data,
   output logic                buf_valid_in,
   output logic [DATA_BIT-1:0] buf_data,
   output logic                buf_rst,
   input  logic                win_valid,
   output logic                acc_en,
   output logic                acc_clear,
   output logic                acc_last,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_idx,
   output logic                busy,
   output logic                done
);

   localparam int PIX = WIDTH * HEIGHT;
   localparam int TGT = (WIDTH - 4) * (HEIGHT - 4);
   localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int WW  = $clog2(TGT + 1);
   localparam int FW  = $clog2(FLUSH_LEN + 1);

   localparam logic [ADDR_BIT-1:0] PIX_A    = ADDR_BIT'(PIX);
   localparam logic [ADDR_BIT-1:0] PIX_LAST = ADDR_BIT'(PIX - 1);
   localparam logic [WW-1:0]       WIN_TGT  = WW'(TGT);
   localparam logic [FW-1:0]       FL_LAST  = FW'(FLUSH_LEN - 1);
   localparam logic [CW-1:0]       CH_LAST  = CW'(CHANNELS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_FEED, S_FLUSH, S_DRAIN, S_NEXT, S_FIN
   } state_t;

   state_t              state, state_nx;
   logic [ADDR_BIT-1:0] pix_cnt;
   logic [ADDR_BIT-1:0] base;
   logic [FW-1:0]       flush_cnt;
   logic [WW-1:0]       win_cnt;
   logic                rd_q;
   logic                vld_q;
   logic                flush_go;
   logic                win_hit;
   logic                stall_i;

`ifdef CONV2_FEED_STALL_EN
   assign stall_i = stall;
`else
   assign stall_i = 1'b0;
`endif

   assign win_hit = win_valid && (win_cnt < WIN_TGT) &&
                    (state == S_FEED || state == S_FLUSH ||
                     state == S_DRAIN);

   assign acc_en       = win_hit;
   assign acc_last     = win_hit && (ch_idx == CH_LAST);
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_FIN);
   assign mem_addr     = (state == S_FEED) ? base + pix_cnt : '0;
   assign buf_valid_in = vld_q;
   // Flush pixels share the registered strobe so they trail RAM data seamlessly.
   assign buf_data     = rd_q ? mem_data : '0;

   always_comb begin
      state_nx  = state;
      mem_rd    = 1'b0;
      flush_go  = 1'b0;
      buf_rst   = 1'b0;
      acc_clear = 1'b0;
      unique case (state)
         S_IDLE: if (start) state_nx = S_CLR;
         S_CLR: begin
            buf_rst   = 1'b1;
            acc_clear = (ch_idx == '0);
            state_nx  = S_FEED;
         end
         S_FEED: if (!stall_i) begin
            mem_rd = 1'b1;
            if (pix_cnt == PIX_LAST) state_nx = S_FLUSH;
         end
         S_FLUSH: if (!stall_i) begin
            flush_go = 1'b1;
            if (flush_cnt == FL_LAST) state_nx = S_DRAIN;
         end
         S_DRAIN: if (win_cnt == WIN_TGT) state_nx = S_NEXT;
         S_NEXT:  state_nx = (ch_idx == CH_LAST) ? S_FIN : S_CLR;
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pix_cnt   <= '0;
         base      <= '0;
         flush_cnt <= '0;
         win_cnt   <= '0;
         ch_idx    <= '0;
         rd_q      <= 1'b0;
         vld_q     <= 1'b0;
      end else begin
         state <= state_nx;
         rd_q  <= mem_rd;
         vld_q <= mem_rd | flush_go;
         if (win_hit) win_cnt <= win_cnt + 1'b1;
         unique case (state)
            S_CLR: begin
               pix_cnt   <= '0;
               flush_cnt <= '0;
               win_cnt   <= '0;
            end
            S_FEED:  if (mem_rd) pix_cnt <= pix_cnt + 1'b1;
            S_FLUSH: if (flush_go) flush_cnt <= flush_cnt + 1'b1;
            S_NEXT: if (ch_idx != CH_LAST) begin
               ch_idx <= ch_idx + 1'b1;
               base   <= base + PIX_A;
            end
            S_FIN: begin
               ch_idx <= '0;
               base   <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv2_feed_ctrl.sv
// Randomized bench for conv2_feed_ctrl with a RAM model, a raster
// window-buffer model and a stream-level scoreboard.
module tb_conv2_feed_ctrl;

   localparam int W     = 12;
   localparam int H     = 12;
   localparam int C     = 3;
   localparam int FL    = 12;
   localparam int PIX   = W * H;
   localparam int TGT   = (W - 4) * (H - 4);
   localparam int TOT   = PIX * C;
   localparam int LIMIT = 3000;

   logic        clk = 0;
   logic        rst;
   logic        start;
   logic        mem_rd;
   logic [8:0]  mem_addr;
   logic [11:0] mem_data = '0;
   logic        buf_valid_in;
   logic [11:0] buf_data;
   logic        buf_rst;
   logic        win_valid = 0;
   logic        acc_en;
   logic        acc_clear;
   logic        acc_last;
   logic [1:0]  ch_idx;
   logic        busy;
   logic        done;
`ifdef CONV2_FEED_STALL_EN
   logic        stall;
`endif

   conv2_feed_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
`ifdef CONV2_FEED_STALL_EN
      .stall        (stall),
`endif
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .buf_valid_in (buf_valid_in),
      .buf_data     (buf_data),
      .buf_rst      (buf_rst),
      .win_valid    (win_valid),
      .acc_en       (acc_en),
      .acc_clear    (acc_clear),
      .acc_last     (acc_last),
      .ch_idx       (ch_idx),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [11:0] ram [0:511];
   always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

   // Window buffer: a window whose bottom-right pixel is raster index n
   // is released lag_n pushes later; extras fire on flush pushes.
   int push_n = 0;
   int lag_n  = 12;
   bit extra_mode = 0;

   function automatic bit is_win(int n);
      return n >= 0 && n < PIX && (n / W) >= 4 && (n % W) >= 4;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         push_n    <= 0;
         win_valid <= 0;
      end else if (buf_rst) begin
         push_n    <= 0;
         win_valid <= 0;
      end else begin
         win_valid <= 0;
         if (buf_valid_in) begin
            push_n    <= push_n + 1;
            win_valid <= is_win(push_n - lag_n) ||
                         (extra_mode && push_n >= PIX &&
                          $urandom_range(0, 1) == 1);
         end
      end
   end

   int tcyc = 0;
   always @(posedge clk) tcyc <= tcyc + 1;

   int          exp_addr;
   int          n_rd, n_bv, n_rst, n_clr, n_acc, n_last, n_done;
   int          last_bv;
   bit          gap_chk;
   logic [11:0] exp_px [$];

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd) begin
            check("rd_addr", mem_addr, exp_addr);
            exp_addr++;
            n_rd++;
         end
         if (buf_valid_in) begin
            if (gap_chk && (n_bv % (PIX + FL)) != 0)
               check("bv_gap", tcyc - last_bv, 1);
            last_bv = tcyc;
            if (exp_px.size() == 0)
               check("bv_extra", n_bv, TOT + C * FL);
            else begin
               logic [11:0] px;
               px = exp_px.pop_front();
               check("bv_data", buf_data, px);
            end
            n_bv++;
         end
         if (buf_rst) begin
            check("rst_ch", ch_idx, n_rst);
            check("rst_busy", busy, 1);
            n_rst++;
         end
         if (acc_clear) begin
            check("clr_ch", ch_idx, 0);
            check("clr_before_acc", n_acc, 0);
            n_clr++;
         end
         if (acc_en) begin
            check("acc_ch", ch_idx, n_acc / TGT);
            check("acc_last", acc_last, n_acc >= (C - 1) * TGT);
            if (acc_last) n_last++;
            n_acc++;
         end else if (acc_last)
            check("last_no_en", acc_last, 0);
`ifdef CONV2_FEED_STALL_EN
         if (stall && mem_rd) check("stall_rd", mem_rd, 0);
`endif
         if (done) n_done++;
      end
   end

   task automatic sb_clear();
      exp_addr = 0;
      n_rd = 0; n_bv = 0; n_rst = 0; n_clr = 0;
      n_acc = 0; n_last = 0; n_done = 0;
      exp_px.delete();
      for (int c = 0; c < C; c++) begin
         for (int p = 0; p < PIX; p++) exp_px.push_back(ram[c * PIX + p]);
         for (int f = 0; f < FL; f++) exp_px.push_back(12'd0);
      end
   endtask

   task automatic run(input bit extra, input int lag, input bit dup,
                      input bit do_stall);
      int cyc;
      int st_left;
      bit st_used;
      extra_mode = extra;
      lag_n      = lag;
      gap_chk    = !do_stall;
      st_left    = 0;
      st_used    = 0;
      sb_clear();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      cyc = 0;
      while (n_done == 0 && cyc < LIMIT) begin
         @(posedge clk); #1;
         start = dup && (cyc == 40 || cyc == 200);
         if (do_stall && exp_addr == 21 && st_left == 0 && !st_used) begin
            st_left = 5;
            st_used = 1;
         end else if (st_left > 0)
            st_left--;
`ifdef CONV2_FEED_STALL_EN
         stall = (st_left > 0);
`endif
         @(negedge clk); #1;
         cyc++;
      end
      start = 0;
      check("timeout", cyc < LIMIT, 1);
      @(negedge clk); #1;
      check("busy_after", busy, 0);
      repeat (5) @(negedge clk);
      #1;
      check("done_once", n_done, 1);
      check("n_rd", n_rd, TOT);
      check("last_addr", exp_addr, TOT);
      check("n_bv", n_bv, TOT + C * FL);
      check("px_left", exp_px.size(), 0);
      check("n_bufrst", n_rst, C);
      check("n_clr", n_clr, 1);
      check("n_acc", n_acc, C * TGT);
      check("n_last", n_last, TGT);
      check("idle_ch", ch_idx, 0);
   endtask

   task automatic run_abort();
      int cyc;
      extra_mode = 0;
      lag_n      = 12;
      gap_chk    = 1;
      sb_clear();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      cyc = 0;
      while (!(mem_rd && mem_addr == 9'd150) && cyc < LIMIT) begin
         @(negedge clk); #1;
         cyc++;
      end
      check("abort_reach", mem_addr, 150);
      check("abort_ch", ch_idx, 1);
      rst = 1;
      #1;
      check("abort_outs", {mem_rd, mem_addr, buf_valid_in, buf_data,
                           buf_rst, acc_en, acc_clear, acc_last,
                           ch_idx, busy, done}, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (20) @(negedge clk);
      #1;
      check("abort_nodone", n_done, 0);
      check("abort_idle", busy, 0);
   endtask

   initial begin
      rst   = 1;
      start = 0;
`ifdef CONV2_FEED_STALL_EN
      stall = 0;
`endif
      for (int i = 0; i < 512; i++) ram[i] = 12'(i);
      sb_clear();
      repeat (3) @(negedge clk);
      check("reset_outs", {mem_rd, mem_addr, buf_valid_in, buf_data,
                           buf_rst, acc_en, acc_clear, acc_last,
                           ch_idx, busy, done}, 0);
      rst = 0;
      @(negedge clk);

      run(0, 12, 0, 0);
      for (int i = 0; i < 512; i++) ram[i] = 12'($urandom);
      run(1, 0, 0, 0);
      run(0, $urandom_range(0, FL), 1, 0);
      run_abort();
      run(0, $urandom_range(0, FL), 0, 0);
`ifdef CONV2_FEED_STALL_EN
      run(0, 12, 0, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/conv2_feed_ctrl.md
Name: conv2_feed_ctrl

Overview:
Sequencer for the conv2 5x5 sliding-window line buffer. It streams each pooled conv1 feature map, one channel at a time, from the feature-map RAM into the window buffer, and flushes the buffer between channels. It counts the windows the buffer produces and generates the accumulate and clear strobes for the per-window partial-sum accumulator. It sits between the pool1 output RAM and the conv2 window buffer and its MAC.

Parameters:
- WIDTH, 12, feature-map width in pixels
- HEIGHT, 12, feature-map height in pixels
- CHANNELS, 3, number of input channels processed sequentially
- DATA_BIT, 12, pixel width
- ADDR_BIT, 9, RAM address width; must satisfy 2^ADDR_BIT >= WIDTH*HEIGHT*CHANNELS
- FLUSH_LEN, 12, zero pixels pushed after each channel so the buffer releases its last row of windows

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to process all channels
- mem_rd  out  1  RAM read strobe
- mem_addr  out  ADDR_BIT  RAM read address; channel c pixel p maps to c*WIDTH*HEIGHT + p
- mem_data  in  DATA_BIT  RAM read data, valid the cycle after mem_rd
- buf_valid_in  out  1  pixel strobe to the window buffer
- buf_data  out  DATA_BIT  pixel to the window buffer
- buf_rst  out  1  synchronous clear pulse to the window buffer
- win_valid  in  1  window-valid from the window buffer
- acc_en  out  1  accumulate the current window into the partial sum
- acc_clear  out  1  clear the partial-sum memory
- acc_last  out  1  acc_en belongs to the final channel
- ch_idx  out  clog2(CHANNELS)  channel currently in flight
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous): all outputs are 0, the FSM is in IDLE, and all counters are 0. Asserting rst mid-run aborts the run immediately; done is not issued. The next start begins again at channel 0.
- FSM states: IDLE, CLR, FEED, FLUSH, DRAIN, NEXT, FIN.
- IDLE: on start=1, go to CLR and set busy=1. start is ignored in every other state.
- CLR (1 cycle): buf_rst=1, win_cnt=0, pix_cnt=0. acc_clear=1 only when ch_idx==0. Then go to FEED.
- FEED: mem_rd=1 every cycle, with mem_addr = base + pix_cnt, where base = ch_idx*WIDTH*HEIGHT.
  - After issuing pix_cnt == WIDTH*HEIGHT-1, go to FLUSH.
  - buf_valid_in is mem_rd delayed one cycle (registered). buf_data = mem_data when that delayed strobe is high.
- FLUSH: FLUSH_LEN cycles with buf_valid_in=1 and buf_data=0, and no RAM reads. The first flush pixel follows the last RAM pixel with no gap.
- DRAIN: wait until win_cnt == (WIDTH-4)*(HEIGHT-4), which is 64 at the defaults, then go to NEXT.
- win_cnt increments on each win_valid while the state is FEED, FLUSH or DRAIN and win_cnt < target.
  - acc_en = win_valid under that same condition (combinational).
  - win_valid pulses beyond the target are masked (acc_en=0) and do not count.
- acc_last = acc_en && ch_idx == CHANNELS-1.
- NEXT: if ch_idx == CHANNELS-1, go to FIN. Otherwise ch_idx++ and return to CLR. acc_clear is not reasserted.
- FIN: done=1 for one cycle, busy=0 on the following cycle, then IDLE.
- The address never exceeds CHANNELS*WIDTH*HEIGHT-1. ch_idx wraps to 0 on the return to IDLE.
- Latency at the defaults with no stall: 1 (CLR) + 144 (FEED) + 12 (FLUSH) + DRAIN cycles + 1 (NEXT) per channel, plus 1 cycle for FIN.

Optional Feature:
- Macro: CONV2_FEED_STALL_EN.
- When defined, the block adds input port stall (1 bit).
  - While stall=1 in FEED, mem_rd=0 and pix_cnt holds. The read already in flight still produces its buf_valid_in.
  - While stall=1 in FLUSH, buf_valid_in=0 and the flush counter holds.
  - win_valid is still counted during a stall.
- When not defined, the port is absent and the block never pauses.

Test Plan:
- Defaults, RAM[i]=i, one start pulse -> 432 mem_rd with addresses 0..431 in order; 3 buf_rst pulses; acc_clear exactly once; 192 acc_en pulses, of which the last 64 have acc_last=1; a single done pulse; busy low afterwards.
- Buffer model drives extra win_valid pulses after 64 windows in a channel -> acc_en stays 0 for the extras and the FSM advances normally.
- Assert rst during FEED of channel 1 (mem_addr=150) -> all outputs 0 immediately; no done; a following start reads from address 0.
- start pulsed again while busy -> ignored; total mem_rd count is still 432 and done pulses once.
- FLUSH check -> exactly 12 buf_valid_in cycles with buf_data=0 immediately after pixel 143 of each channel.
- With CONV2_FEED_STALL_EN, stall=1 for 5 cycles at pix_cnt=20 -> no mem_rd during the stall; addresses resume at 21 with no skip or duplicate; totals are unchanged.
